// File: rtl/ee354_gcd_scheduler_if.sv
// Requester and GCD-core signal bundle for the scheduler.
// slave = the scheduler; master = requesters plus the core they share.
interface ee354_gcd_scheduler_if #(
    parameter int NREQ = 2,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ack;
    logic [DW-1:0]      rsp_gcd;
    logic [15:0]        rsp_cycles;
    logic               rsp_err;
    logic               busy;
    logic               gcd_CEN;
    logic               gcd_Start;
    logic               gcd_Ack;
    logic [DW-1:0]      gcd_Ain;
    logic [DW-1:0]      gcd_Bin;
    logic [DW-1:0]      gcd_AB_GCD;
    logic               gcd_q_Sub;
    logic               gcd_q_Done;

    modport master (
        output req_valid, req_a, req_b, rsp_ack, gcd_AB_GCD, gcd_q_Sub, gcd_q_Done,
        input  req_ready, rsp_valid, rsp_gcd, rsp_cycles, rsp_err, busy,
               gcd_CEN, gcd_Start, gcd_Ack, gcd_Ain, gcd_Bin
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ack, gcd_AB_GCD, gcd_q_Sub, gcd_q_Done,
        output req_ready, rsp_valid, rsp_gcd, rsp_cycles, rsp_err, busy,
               gcd_CEN, gcd_Start, gcd_Ack, gcd_Ain, gcd_Bin
    );
endinterface

// File: rtl/ee354_gcd_scheduler.sv
// Round-robin scheduler sharing one ee354_GCD core among NREQ requesters.
// Handshake: an operand set transfers on a CEN-enabled edge where req_ready[i]=1; a response is consumed on an enabled edge where rsp_valid[i] and rsp_ack[i] are both 1.
module ee354_gcd_scheduler #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int TMO  = 1023
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CEN,
    ee354_gcd_scheduler_if.slave  bus,
    output logic [2:0]            dbg_state_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   id_q;
    logic [15:0]     cyc_q;
    logic            seen_q;
    logic [TW-1:0]   tmo_q;
    logic [DW-1:0]   ain_q;
    logic [DW-1:0]   bin_q;
    logic [DW-1:0]   gcd_q;
    logic [15:0]     cycles_q;
    logic            err_q;
    logic            start_q;
    logic            ack_q;

    logic            any_d;
    logic [IW-1:0]   win_d;
    logic [IW-1:0]   arb_idx;
    logic [DW-1:0]   sel_a_d;
    logic [DW-1:0]   sel_b_d;

    // Search starts one past the last winner so every waiter is reached within NREQ jobs.
    always_comb begin
        any_d   = 1'b0;
        win_d   = '0;
        arb_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!any_d && bus.req_valid[arb_idx]) begin
                any_d = 1'b1;
                win_d = arb_idx;
            end
        end
        sel_a_d = bus.req_a[int'(win_d)*DW +: DW];
        sel_b_d = bus.req_b[int'(win_d)*DW +: DW];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            cyc_q    <= '0;
            seen_q   <= 1'b0;
            tmo_q    <= '0;
            ain_q    <= '0;
            bin_q    <= '0;
            gcd_q    <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else if (CEN) begin
            case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        rr_ptr_q <= win_d;
                        id_q     <= win_d;
                        ain_q    <= sel_a_d;
                        bin_q    <= sel_b_d;
                        // A zero operand would never terminate in the core, so answer directly.
                        if (sel_a_d == '0 || sel_b_d == '0) begin
                            err_q    <= 1'b1;
                            gcd_q    <= '0;
                            cycles_q <= '0;
                            state_q  <= S_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    start_q <= 1'b0;
                    cyc_q   <= '0;
                    seen_q  <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.gcd_q_Done) begin
                        gcd_q    <= bus.gcd_AB_GCD;
                        err_q    <= 1'b0;
                        cycles_q <= cyc_q;
                        state_q  <= S_RESP;
                    end else if (tmo_q == TW'(TMO - 1)) begin
                        gcd_q    <= '0;
                        err_q    <= 1'b1;
                        cycles_q <= cyc_q;
                        state_q  <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (bus.gcd_q_Sub || seen_q) begin
                            seen_q <= 1'b1;
                            if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ack[id_q]) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (!Reset && CEN && state_q == S_IDLE && any_d) ? (NREQ'(1) << win_d) : '0;
    assign bus.rsp_valid  = (state_q == S_RESP) ? (NREQ'(1) << id_q) : '0;
    assign bus.rsp_gcd    = gcd_q;
    assign bus.rsp_cycles = cycles_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.gcd_CEN    = CEN;
    assign bus.gcd_Start  = start_q;
    assign bus.gcd_Ack    = ack_q;
    assign bus.gcd_Ain    = ain_q;
    assign bus.gcd_Bin    = bin_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_ee354_gcd_scheduler.sv
// Directed bench for ee354_gcd_scheduler with a small subtractive GCD core model.
// Each scenario task drives its own stimulus and checks inline.
module tb_ee354_gcd_scheduler;
    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    localparam logic [1:0] C_I    = 2'd0;
    localparam logic [1:0] C_SUB  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       hang;
    logic [2:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    ee354_gcd_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    ee354_gcd_scheduler #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .Clk         (clk),
        .Reset       (rst),
        .CEN         (cen),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Core model: subtract smaller from larger until equal; hang keeps it in q_Sub.
    logic [1:0]    cst;
    logic [DW-1:0] ca;
    logic [DW-1:0] cb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst <= C_I;
            ca  <= '0;
            cb  <= '0;
        end else if (bus.gcd_CEN) begin
            case (cst)
                C_I: if (bus.gcd_Start) begin
                    ca  <= bus.gcd_Ain;
                    cb  <= bus.gcd_Bin;
                    cst <= C_SUB;
                end
                C_SUB: if (!hang) begin
                    if (ca == cb)     cst <= C_DONE;
                    else if (ca > cb) ca  <= ca - cb;
                    else              cb  <= cb - ca;
                end
                C_DONE: if (bus.gcd_Ack) cst <= C_I;
                default: cst <= C_I;
            endcase
        end
    end

    assign bus.gcd_AB_GCD = ca;
    assign bus.gcd_q_Sub  = (cst == C_SUB);
    assign bus.gcd_q_Done = (cst == C_DONE);

    task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (idx == 0) begin
            bus.req_a[7:0] = a;
            bus.req_b[7:0] = b;
        end else begin
            bus.req_a[15:8] = a;
            bus.req_b[15:8] = b;
        end
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (dbg_state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b1;
        hang = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ack = '0;
        bus.req_valid = 2'b01;
        #1;
        n_total++;
        if (dbg_state !== S_IDLE) $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_IDLE); else n_pass++;
        n_total++;
        if (bus.req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", bus.req_ready); else n_pass++;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_Start, bus.gcd_Ack} !== 6'b0)
            $display("FAIL rst_ctrl: got %b expected 000000",
                     {bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_Start, bus.gcd_Ack});
        else n_pass++;
        n_total++;
        if ({bus.rsp_gcd, bus.rsp_cycles, bus.gcd_Ain, bus.gcd_Bin} !== 40'h0)
            $display("FAIL rst_data: got %h expected 0", {bus.rsp_gcd, bus.rsp_cycles, bus.gcd_Ain, bus.gcd_Bin});
        else n_pass++;
        repeat (2) @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        logic prev_done;
        set_req(0, 8'd36, 8'd24);
        bus.req_valid = 2'b01;
        #1;
        n_total++;
        if (bus.req_ready !== 2'b01) $display("FAIL t1_ready: got %b expected 01", bus.req_ready); else n_pass++;
        @(negedge clk);
        bus.req_valid = '0;
        n_total++;
        if ({dbg_state, bus.gcd_Start, bus.busy} !== {S_LAUNCH, 1'b1, 1'b1})
            $display("FAIL t1_launch: got %b expected %b", {dbg_state, bus.gcd_Start, bus.busy}, {S_LAUNCH, 2'b11});
        else n_pass++;
        n_total++;
        if ({bus.gcd_Ain, bus.gcd_Bin} !== {8'd36, 8'd24})
            $display("FAIL t1_operands: got %0d,%0d expected 36,24", bus.gcd_Ain, bus.gcd_Bin);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({dbg_state, bus.gcd_Start} !== {S_WAIT, 1'b0})
            $display("FAIL t1_start_pulse: got %b expected %b", {dbg_state, bus.gcd_Start}, {S_WAIT, 1'b0});
        else n_pass++;
        n = 0;
        prev_done = 1'b0;
        while (bus.rsp_valid == '0 && n < 40) begin
            prev_done = bus.gcd_q_Done;
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== 4) $display("FAIL t1_wait_len: got %0d expected 4", n); else n_pass++;
        n_total++;
        if (prev_done !== 1'b1) $display("FAIL t1_done_latency: got %b expected 1", prev_done); else n_pass++;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_gcd, bus.rsp_err} !== {2'b01, 8'd12, 1'b0})
            $display("FAIL t1_rsp: got v=%b gcd=%0d err=%b expected v=01 gcd=12 err=0",
                     bus.rsp_valid, bus.rsp_gcd, bus.rsp_err);
        else n_pass++;
        n_total++;
        if (bus.rsp_cycles !== 16'd3) $display("FAIL t1_cycles: got %0d expected 3", bus.rsp_cycles); else n_pass++;
        bus.rsp_ack = 2'b10;
        @(negedge clk);
        bus.rsp_ack = '0;
        n_total++;
        if ({dbg_state, bus.rsp_valid, bus.rsp_gcd} !== {S_RESP, 2'b01, 8'd12})
            $display("FAIL t1_wrong_ack: got %h expected %h", {dbg_state, bus.rsp_valid, bus.rsp_gcd}, {S_RESP, 2'b01, 8'd12});
        else n_pass++;
        bus.rsp_ack = 2'b01;
        @(negedge clk);
        bus.rsp_ack = '0;
        n_total++;
        if ({dbg_state, bus.gcd_Ack, bus.rsp_valid} !== {S_ACK, 1'b1, 2'b00})
            $display("FAIL t1_ack_pulse: got %b expected %b", {dbg_state, bus.gcd_Ack, bus.rsp_valid}, {S_ACK, 3'b100});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({dbg_state, bus.gcd_Ack, bus.busy} !== {S_IDLE, 2'b00})
            $display("FAIL t1_back_idle: got %b expected %b", {dbg_state, bus.gcd_Ack, bus.busy}, {S_IDLE, 2'b00});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int n;
        set_req(0, 8'd15, 8'd5);
        set_req(1, 8'd21, 8'd14);
        bus.req_valid = 2'b11;
        #1;
        n_total++;
        if (bus.req_ready !== 2'b10) $display("FAIL t2_first_grant: got %b expected 10", bus.req_ready); else n_pass++;
        @(negedge clk);
        bus.req_valid = 2'b01;
        wait_rsp(40, n);
        n_total++;
        if ({bus.rsp_valid, bus.rsp_gcd, bus.rsp_cycles} !== {2'b10, 8'd7, 16'd3})
            $display("FAIL t2_rsp1: got v=%b gcd=%0d cyc=%0d expected v=10 gcd=7 cyc=3",
                     bus.rsp_valid, bus.rsp_gcd, bus.rsp_cycles);
        else n_pass++;
        n_total++;
        if (bus.req_ready !== 2'b00) $display("FAIL t2_busy_ready: got %b expected 00", bus.req_ready); else n_pass++;
        bus.rsp_ack = 2'b10;
        @(negedge clk);
        bus.rsp_ack = '0;
        n = 1;
        while (!bus.req_ready[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== 2) $display("FAIL t2_ack_to_grant: got %0d expected 2", n); else n_pass++;
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, n);
        n_total++;
        if ({bus.rsp_valid, bus.rsp_gcd, bus.rsp_err} !== {2'b01, 8'd5, 1'b0})
            $display("FAIL t2_rsp0: got v=%b gcd=%0d err=%b expected v=01 gcd=5 err=0",
                     bus.rsp_valid, bus.rsp_gcd, bus.rsp_err);
        else n_pass++;
        bus.rsp_ack = 2'b01;
        @(negedge clk);
        bus.rsp_ack = '0;
        @(negedge clk);
    endtask

    task automatic test_zero_operand();
        int            idx_v [2] = '{0, 1};
        logic [DW-1:0] a_v   [2] = '{8'd0, 8'd5};
        logic [DW-1:0] b_v   [2] = '{8'd9, 8'd0};
        logic [1:0]    oh;
        for (int v = 0; v < 2; v++) begin
            oh = 2'b01 << idx_v[v];
            set_req(idx_v[v], a_v[v], b_v[v]);
            bus.req_valid = oh;
            #1;
            n_total++;
            if (bus.req_ready !== oh) $display("FAIL t3_ready%0d: got %b expected %b", v, bus.req_ready, oh); else n_pass++;
            @(negedge clk);
            bus.req_valid = '0;
            n_total++;
            if ({dbg_state, bus.rsp_valid, bus.rsp_err, bus.rsp_gcd, bus.gcd_Start} !== {S_RESP, oh, 1'b1, 8'd0, 1'b0})
                $display("FAIL t3_err%0d: got %h expected %h", v,
                         {dbg_state, bus.rsp_valid, bus.rsp_err, bus.rsp_gcd, bus.gcd_Start},
                         {S_RESP, oh, 1'b1, 8'd0, 1'b0});
            else n_pass++;
            bus.rsp_ack = oh;
            @(negedge clk);
            bus.rsp_ack = '0;
            n_total++;
            if ({dbg_state, bus.gcd_Ack} !== {S_ACK, 1'b1})
                $display("FAIL t3_ack%0d: got %b expected %b", v, {dbg_state, bus.gcd_Ack}, {S_ACK, 1'b1});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_cen_toggle();
        int            frozen_bad = 0;
        int            cen_bad = 0;
        int            starts = 0;
        int            acks = 0;
        bit            done = 0;
        bit            got_rsp = 0;
        bit            grant;
        bit            ack_set = 0;
        bit            used;
        logic [2:0]    st;
        logic [DW-1:0] g = '0;
        logic [15:0]   c = '0;
        logic          e = 1'b1;
        set_req(0, 8'd36, 8'd24);
        bus.req_valid = 2'b01;
        cen = 1'b0;
        #1;
        n_total++;
        if (bus.req_ready !== 2'b00) $display("FAIL t4_ready_cen0: got %b expected 00", bus.req_ready); else n_pass++;
        @(negedge clk);
        n_total++;
        if (dbg_state !== S_IDLE) $display("FAIL t4_no_grant: got %0d expected %0d", dbg_state, S_IDLE); else n_pass++;
        for (int i = 0; i < 200 && !done; i++) begin
            cen = ~cen;
            #1;
            if (bus.gcd_CEN !== cen) cen_bad++;
            grant = cen && bus.req_ready[0];
            if (cen && bus.gcd_Start) starts++;
            if (cen && bus.gcd_Ack) acks++;
            if (cen && bus.rsp_valid[0] && !got_rsp) begin
                got_rsp = 1;
                g = bus.rsp_gcd;
                c = bus.rsp_cycles;
                e = bus.rsp_err;
                bus.rsp_ack = 2'b01;
                ack_set = 1;
            end
            st = dbg_state;
            used = cen;
            @(negedge clk);
            if (!used && dbg_state !== st) frozen_bad++;
            if (grant) bus.req_valid = '0;
            if (ack_set) begin
                bus.rsp_ack = '0;
                ack_set = 0;
            end
            if (acks > 0 && dbg_state == S_IDLE) done = 1;
        end
        cen = 1'b1;
        n_total++;
        if (!done) $display("FAIL t4_complete: got 0 expected 1"); else n_pass++;
        n_total++;
        if (frozen_bad !== 0) $display("FAIL t4_frozen: got %0d moves expected 0", frozen_bad); else n_pass++;
        n_total++;
        if (cen_bad !== 0) $display("FAIL t4_gcd_cen: got %0d diffs expected 0", cen_bad); else n_pass++;
        n_total++;
        if ({starts, acks} !== {32'd1, 32'd1}) $display("FAIL t4_pulses: got start=%0d ack=%0d expected 1,1", starts, acks); else n_pass++;
        n_total++;
        if ({g, c, e} !== {8'd12, 16'd3, 1'b0})
            $display("FAIL t4_rsp: got gcd=%0d cyc=%0d err=%b expected gcd=12 cyc=3 err=0", g, c, e);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        hang = 1'b1;
        set_req(0, 8'd40, 8'd25);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        wait_state(S_WAIT, 10, n);
        wait_rsp(40, n);
        n_total++;
        if (n !== 16) $display("FAIL t5_tmo_len: got %0d expected 16", n); else n_pass++;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_gcd} !== {2'b01, 1'b1, 8'd0})
            $display("FAIL t5_tmo_rsp: got v=%b err=%b gcd=%0d expected v=01 err=1 gcd=0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_gcd);
        else n_pass++;
        bus.rsp_ack = 2'b01;
        @(negedge clk);
        bus.rsp_ack = '0;
        n_total++;
        if (bus.gcd_Ack !== 1'b1) $display("FAIL t5_ack: got %b expected 1", bus.gcd_Ack); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        set_req(0, 8'd30, 8'd20);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        wait_state(S_WAIT, 10, n);
        repeat (3) @(negedge clk);
        n_total++;
        if (dbg_state !== S_WAIT) $display("FAIL t6_in_wait: got %0d expected %0d", dbg_state, S_WAIT); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({dbg_state, bus.busy, bus.rsp_valid, bus.gcd_Start, bus.gcd_Ack} !== 8'b0)
            $display("FAIL t6_async_clear: got %b expected 00000000",
                     {dbg_state, bus.busy, bus.rsp_valid, bus.gcd_Start, bus.gcd_Ack});
        else n_pass++;
        n_total++;
        if ({bus.gcd_Ain, bus.gcd_Bin} !== 16'h0)
            $display("FAIL t6_operands_clear: got %h expected 0000", {bus.gcd_Ain, bus.gcd_Bin});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        hang = 1'b0;
        set_req(1, 8'd18, 8'd12);
        bus.req_valid = 2'b10;
        #1;
        n_total++;
        if (bus.req_ready !== 2'b10) $display("FAIL t6_regrant: got %b expected 10", bus.req_ready); else n_pass++;
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, n);
        n_total++;
        if ({bus.rsp_valid, bus.rsp_gcd, bus.rsp_cycles, bus.rsp_err} !== {2'b10, 8'd6, 16'd3, 1'b0})
            $display("FAIL t6_rsp: got v=%b gcd=%0d cyc=%0d err=%b expected v=10 gcd=6 cyc=3 err=0",
                     bus.rsp_valid, bus.rsp_gcd, bus.rsp_cycles, bus.rsp_err);
        else n_pass++;
        bus.rsp_ack = 2'b10;
        @(negedge clk);
        bus.rsp_ack = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_operand();
        test_cen_toggle();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
